// File: rtl/sync_counter_param.sv
// Parametrised single-edge synchronous up/down counter with modulus, load,
// wrap/saturate mode, cascadable terminal count and sticky overflow.
module sync_counter_param #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap_p,
  output logic             ovf_sticky
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);

  logic           at_max;
  logic           at_zero;
  logic           boundary;
  logic           bnd_event;
  logic [WIDTH:0] nxt;

  assign at_max    = (cnt == MAX);
  assign at_zero   = (cnt == '0);
  assign boundary  = (up & at_max) | (~up & at_zero);
  assign tc        = en & boundary;
  assign bnd_event = en & ~load & boundary;

  always_comb begin
    nxt = {1'b0, cnt};
    if (load) begin
      nxt = ({1'b0, load_val} > MAX_X) ? MAX_X : {1'b0, load_val};
    end else if (en) begin
      if (up) begin
        if (at_max) nxt = (SATURATE != 0) ? MAX_X : '0;
        else        nxt = {1'b0, cnt} + (WIDTH+1)'(1);
      end else begin
        if (at_zero) nxt = (SATURATE != 0) ? '0 : MAX_X;
        else         nxt = {1'b0, cnt} - (WIDTH+1)'(1);
      end
    end
  end

  // Final range guard keeps cnt inside 0..MAX whatever nxt computes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      wrap_p     <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      cnt        <= (nxt > MAX_X) ? MAX : nxt[WIDTH-1:0];
      wrap_p     <= bnd_event;
      ovf_sticky <= bnd_event | (ovf_sticky & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_sync_counter_param.sv
// Directed bench for sync_counter_param: wrapping and saturating MODULUS=10
// instances plus a full-range MODULUS=16 instance, all sharing one input set.
module tb_sync_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       ovf_clr = 1'b0;

  logic [3:0] cnt_w, cnt_s, cnt_f;
  logic       tc_w, tc_s, tc_f;
  logic       wrap_w, wrap_s, wrap_f;
  logic       ovf_w, ovf_s, ovf_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .cnt(cnt_w), .tc(tc_w), .wrap_p(wrap_w), .ovf_sticky(ovf_w));

  sync_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .cnt(cnt_s), .tc(tc_s), .wrap_p(wrap_s), .ovf_sticky(ovf_s));

  sync_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_full (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .cnt(cnt_f), .tc(tc_f), .wrap_p(wrap_f), .ovf_sticky(ovf_f));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; ovf_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0; load = 1'b0;
    if ({cnt_w, wrap_w, ovf_w} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_wrap: cnt/wrap/ovf got %0d/%0b/%0b want 0/0/0", cnt_w, wrap_w, ovf_w);
      miscompares++;
    end
    vectors++;
    if ({cnt_s, wrap_s, ovf_s} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_sat: cnt/wrap/ovf got %0d/%0b/%0b want 0/0/0", cnt_s, wrap_s, ovf_s);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_count_up();
    logic [3:0] ec;
    apply_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = 4'(i % 10);
      if ({cnt_w, tc_w, wrap_w, ovf_w} !== {ec, (ec == 4'd9), (i == 10), (i >= 10)}) begin
        $display("FAIL count_up[%0d]: cnt/tc/wrap/ovf got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                 i, cnt_w, tc_w, wrap_w, ovf_w, ec, (ec == 4'd9), (i == 10), (i >= 10));
        miscompares++;
      end
      vectors++;
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    apply_reset();
    en = 1'b1; up = 1'b0;
    #1;
    if (tc_w !== 1'b1) begin
      $display("FAIL down_tc_at_zero: tc got %0b want 1", tc_w);
      miscompares++;
    end
    vectors++;
    step();
    if ({cnt_w, tc_w, wrap_w} !== {4'd9, 1'b0, 1'b1}) begin
      $display("FAIL down_wrap: cnt/tc/wrap got %0d/%0b/%0b want 9/0/1", cnt_w, tc_w, wrap_w);
      miscompares++;
    end
    vectors++;
    step();
    if ({cnt_w, wrap_w} !== {4'd8, 1'b0}) begin
      $display("FAIL down_step: cnt/wrap got %0d/%0b want 8/0", cnt_w, wrap_w);
      miscompares++;
    end
    vectors++;
    en = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    load = 1'b1; load_val = 4'd8;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if ({cnt_s, tc_s, wrap_s, ovf_s} !== {4'd9, 1'b1, (i >= 2), (i >= 2)}) begin
        $display("FAIL sat_up[%0d]: cnt/tc/wrap/ovf got %0d/%0b/%0b/%0b want 9/1/%0b/%0b",
                 i, cnt_s, tc_s, wrap_s, ovf_s, (i >= 2), (i >= 2));
        miscompares++;
      end
      vectors++;
    end
    apply_reset();
    en = 1'b1; up = 1'b0;
    step();
    if ({cnt_s, wrap_s, ovf_s} !== {4'd0, 1'b1, 1'b1}) begin
      $display("FAIL sat_down_hold: cnt/wrap/ovf got %0d/%0b/%0b want 0/1/1", cnt_s, wrap_s, ovf_s);
      miscompares++;
    end
    vectors++;
    en = 1'b0;
  endtask

  task automatic test_load();
    apply_reset();
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd13;
    step();
    if ({cnt_w, wrap_w, ovf_w} !== {4'd9, 1'b0, 1'b0}) begin
      $display("FAIL load_clamp: cnt/wrap/ovf got %0d/%0b/%0b want 9/0/0", cnt_w, wrap_w, ovf_w);
      miscompares++;
    end
    vectors++;
    if (cnt_f !== 4'd13) begin
      $display("FAIL load_full_noclamp: cnt got %0d want 13", cnt_f);
      miscompares++;
    end
    vectors++;
    load_val = 4'd5;
    #1;
    if (tc_w !== 1'b1) begin
      $display("FAIL tc_ignores_load: tc got %0b want 1", tc_w);
      miscompares++;
    end
    vectors++;
    step();
    if ({cnt_w, wrap_w, ovf_w} !== {4'd5, 1'b0, 1'b0}) begin
      $display("FAIL load_over_wrap: cnt/wrap/ovf got %0d/%0b/%0b want 5/0/0", cnt_w, wrap_w, ovf_w);
      miscompares++;
    end
    vectors++;
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_ovf_clr();
    apply_reset();
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1; ovf_clr = 1'b1;
    step();
    if ({cnt_w, wrap_w, ovf_w} !== {4'd0, 1'b1, 1'b1}) begin
      $display("FAIL ovf_set_wins: cnt/wrap/ovf got %0d/%0b/%0b want 0/1/1", cnt_w, wrap_w, ovf_w);
      miscompares++;
    end
    vectors++;
    en = 1'b0;
    step();
    if ({cnt_w, wrap_w, ovf_w} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL ovf_clear: cnt/wrap/ovf got %0d/%0b/%0b want 0/0/0", cnt_w, wrap_w, ovf_w);
      miscompares++;
    end
    vectors++;
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    load = 1'b1;
    step();
    if ({cnt_w, wrap_w, ovf_w} !== {4'd9, 1'b0, 1'b1}) begin
      $display("FAIL premid_state: cnt/wrap/ovf got %0d/%0b/%0b want 9/0/1", cnt_w, wrap_w, ovf_w);
      miscompares++;
    end
    vectors++;
    load = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    if ({cnt_w, wrap_w, ovf_w} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_mid: cnt/wrap/ovf got %0d/%0b/%0b want 0/0/0", cnt_w, wrap_w, ovf_w);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_full_modulus();
    apply_reset();
    load = 1'b1; load_val = 4'd15;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    if (tc_f !== 1'b1) begin
      $display("FAIL full_tc: tc got %0b want 1", tc_f);
      miscompares++;
    end
    vectors++;
    step();
    if ({cnt_f, wrap_f} !== {4'd0, 1'b1}) begin
      $display("FAIL full_wrap_up: cnt/wrap got %0d/%0b want 0/1", cnt_f, wrap_f);
      miscompares++;
    end
    vectors++;
    up = 1'b0;
    step();
    if ({cnt_f, wrap_f} !== {4'd15, 1'b1}) begin
      $display("FAIL full_wrap_down: cnt/wrap got %0d/%0b want 15/1", cnt_f, wrap_f);
      miscompares++;
    end
    vectors++;
    en = 1'b0;
  endtask

  // Reference step for a MODULUS=10 counter in plain integer arithmetic.
  function automatic int model_next(int c, bit e, bit u, bit l, int lv, bit sat);
    if (l) return (lv > 9) ? 9 : lv;
    if (!e) return c;
    if (u) return (c == 9) ? (sat ? 9 : 0) : c + 1;
    return (c == 0) ? (sat ? 0 : 9) : c - 1;
  endfunction

  task automatic test_random();
    int mw, ms, nw, ns;
    bit ew, es;
    apply_reset();
    mw = 0; ms = 0;
    for (int i = 0; i < 200; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      #1;
      if ({tc_w, tc_s} !== {en && ((up && mw == 9) || (!up && mw == 0)),
                            en && ((up && ms == 9) || (!up && ms == 0))}) begin
        $display("FAIL rand_tc[%0d]: tc_w/tc_s got %0b/%0b model cnt %0d/%0d", i, tc_w, tc_s, mw, ms);
        miscompares++;
      end
      vectors++;
      ew = en && !load && ((up && mw == 9) || (!up && mw == 0));
      es = en && !load && ((up && ms == 9) || (!up && ms == 0));
      nw = model_next(mw, en, up, load, int'(load_val), 1'b0);
      ns = model_next(ms, en, up, load, int'(load_val), 1'b1);
      step();
      mw = nw; ms = ns;
      if ({cnt_w, wrap_w, cnt_s, wrap_s} !== {4'(mw), ew, 4'(ms), es}) begin
        $display("FAIL rand_state[%0d]: cnt_w/wrap_w/cnt_s/wrap_s got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b",
                 i, cnt_w, wrap_w, cnt_s, wrap_s, mw, ew, ms, es);
        miscompares++;
      end
      vectors++;
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load();
    test_ovf_clr();
    test_reset_mid();
    test_full_modulus();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
